// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer
// Instruction fetch front end: owns the fetch PC, issues reads to a
// synchronous instruction ROM and queues the returned words in a 2-entry
// prefetch FIFO that feeds the IF/ID stage one instruction per cycle.
// A branch redirect flushes the FIFO and drops any response still on its
// way back from the ROM.
//
// Flow control is credit based: the FIFO occupancy plus the single ROM read
// that can be outstanding must never exceed the two FIFO slots. That way a
// response always has a slot waiting for it and the ROM never needs to be
// stalled.

module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  // Fetch PC and the bookkeeping for the one outstanding ROM read.
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        inflight_q;
  logic        inflight_d;
  logic [31:0] inflight_pc_q;
  logic [31:0] inflight_pc_d;

  // Two-entry FIFO of {pc, inst}. A 1-bit pointer is enough for two slots.
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];
  logic        rd_ptr_q;
  logic        rd_ptr_d;
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic [1:0]  occ_q;
  logic [1:0]  occ_d;

  // Per-cycle control decisions.
  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [1:0]  credit_s;
  logic [31:0] branch_pc_s;

  // Word-aligned redirect address. Masking rather than slicing keeps every
  // target bit in use while forcing the low two bits to zero.
  assign branch_pc_s = branch_target_i & 32'hFFFF_FFFC;

  // Slots already spoken for: buffered entries plus the read coming back.
  assign credit_s = occ_q + {1'b0, inflight_q};

  // Pop / push / issue decisions. A branch overrides all of them: the head is
  // discarded instead of consumed and the arriving response is dropped.
  always_comb begin
    pop_s   = 1'b0;
    push_s  = 1'b0;
    issue_s = 1'b0;
    if (branch_flag_i) begin
      pop_s   = 1'b0;
      push_s  = 1'b0;
      issue_s = 1'b0;
    end else begin
      pop_s  = (occ_q != 2'd0) && !stall_i;
      push_s = inflight_q;
      if (rst) begin
        issue_s = 1'b0;
      end else if (credit_s < 2'd2) begin
        issue_s = 1'b1;
      end else if ((credit_s == 2'd2) && pop_s) begin
        // The pop this cycle frees the slot the new read will land in.
        issue_s = 1'b1;
      end else begin
        issue_s = 1'b0;
      end
    end
  end

  // Next-state logic for the PC, the in-flight tracker and the FIFO control.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    if (branch_flag_i) begin
      // Redirect: flush everything. Pointers are rewound as well so the head
      // is slot 0 again after every flush.
      pc_d       = branch_pc_s;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      occ_d      = 2'd0;
    end else begin
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      // Push and pop together leave the occupancy unchanged; the credit
      // rule keeps a push into a full FIFO from ever happening.
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
      if (issue_s) begin
        // PC increment wraps naturally at 2^32.
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end else begin
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        pc_d          = pc_q;
      end
    end
  end

  // Control state registers; reset is asynchronous so outputs drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
    end
  end

  // FIFO storage: capture the ROM response with the address that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_pc_q[0]   <= 32'h0000_0000;
      fifo_pc_q[1]   <= 32'h0000_0000;
      fifo_inst_q[0] <= 32'h0000_0000;
      fifo_inst_q[1] <= 32'h0000_0000;
    end else if (push_s) begin
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      fifo_inst_q[wr_ptr_q] <= rom_data_i;
    end else begin
      fifo_pc_q[wr_ptr_q]   <= fifo_pc_q[wr_ptr_q];
      fifo_inst_q[wr_ptr_q] <= fifo_inst_q[wr_ptr_q];
    end
  end

  // ROM request is combinational so a pop can free a slot in the same cycle.
  assign rom_ce_o   = issue_s;
  assign rom_addr_o = pc_q;

  // Head of the FIFO straight from registers; stale when the FIFO is empty.
  assign inst_valid_o = (occ_q != 2'd0);
  assign inst_o       = fifo_inst_q[rd_ptr_q];
  assign pc_o         = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer
// Directed vector table plus randomized stream checked against a queue-based
// reference model of the fetch buffer. A second instance starts near the top
// of the address space to exercise PC wrap-around.

module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] rom_data;
  logic [31:0] rom_data_w;

  logic        ce,    w_ce;
  logic [31:0] addr,  w_addr;
  logic        valid, w_valid;
  logic [31:0] inst,  w_inst;
  logic [31:0] pc,    w_pc;

  inst_fetch_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(ce), .rom_addr_o(addr), .rom_data_i(rom_data),
    .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .inst_valid_o(valid), .inst_o(inst), .pc_o(pc)
  );

  inst_fetch_buffer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .rom_ce_o(w_ce), .rom_addr_o(w_addr), .rom_data_i(rom_data_w),
    .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .inst_valid_o(w_valid), .inst_o(w_inst), .pc_o(w_pc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ROM contents: a fixed scramble of the address so inst differs from pc.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'hC3A5_0000 ^ {a[7:0], 24'h000000};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: fetch PC, FIFO as a queue, one outstanding read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_inf;
  logic [31:0] m_inf_pc;

  // ROM request seen last cycle, per instance.
  bit          r_ce, r_ce_w;
  logic [31:0] r_addr, r_addr_w;

  // Outputs sampled in the most recent cycle.
  logic        s_ce, s_valid, s_wvalid;
  logic [31:0] s_addr, s_pc, s_inst, s_wpc, s_winst;

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0000_0000;
    m_inf    = 1'b0;
    m_inf_pc = 32'h0000_0000;
    r_ce     = 1'b0;
    r_ce_w   = 1'b0;
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input bit s, input bit b, input logic [31:0] t);
    bit          e_valid, e_pop, e_ce;
    int          credit;
    ent_t        hd;
    stall      = s;
    br         = b;
    tgt        = t;
    rom_data   = r_ce   ? rom_fn(r_addr)   : 32'hDEAD_BEEF;
    rom_data_w = r_ce_w ? rom_fn(r_addr_w) : 32'hDEAD_BEEF;
    @(negedge clk);
    s_ce = ce; s_addr = addr; s_valid = valid; s_pc = pc; s_inst = inst;
    s_wvalid = w_valid; s_wpc = w_pc; s_winst = w_inst;

    e_valid = (m_q.size() != 0);
    e_pop   = e_valid && !s && !b;
    credit  = m_q.size() + (m_inf ? 1 : 0);
    e_ce    = !b && ((credit < 2) || (credit == 2 && e_pop));
    check("model_ce",    {31'd0, ce},    {31'd0, e_ce});
    check("model_addr",  addr,           m_pc);
    check("model_valid", {31'd0, valid}, {31'd0, e_valid});
    if (e_valid) begin
      hd = m_q[0];
      check("model_pc",   pc,   hd.pc);
      check("model_inst", inst, hd.inst);
    end

    r_ce = ce; r_addr = addr; r_ce_w = w_ce; r_addr_w = w_addr;

    if (b) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = {t[31:2], 2'b00};
    end else begin
      if (e_pop) hd = m_q.pop_front();
      if (m_inf) m_q.push_back('{pc: m_inf_pc, inst: rom_fn(m_inf_pc)});
      if (e_ce) begin
        m_inf    = 1'b1;
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end else begin
        m_inf = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          s;
    bit          b;
    logic [31:0] t;
    bit          e_ce;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_wpc;
  } vec_t;

  function automatic vec_t mk(bit s, bit b, logic [31:0] t, bit c, logic [31:0] a,
                              bit v, logic [31:0] p, logic [31:0] wp);
    vec_t r;
    r.s = s; r.b = b; r.t = t; r.e_ce = c; r.e_addr = a;
    r.e_valid = v; r.e_pc = p; r.e_wpc = wp;
    return r;
  endfunction

  vec_t tbl[17];

  initial begin
    // Hand-derived cycle-by-cycle expectations from reset release.
    tbl[0]  = mk(0, 0, 32'h0,   1, 32'h000, 0, 32'h000, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,   1, 32'h004, 0, 32'h000, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,   1, 32'h008, 1, 32'h000, 32'hFFFF_FFF8);
    tbl[3]  = mk(1, 0, 32'h0,   0, 32'h00C, 1, 32'h004, 32'hFFFF_FFFC);
    tbl[4]  = mk(1, 0, 32'h0,   0, 32'h00C, 1, 32'h004, 32'hFFFF_FFFC);
    tbl[5]  = mk(0, 0, 32'h0,   1, 32'h00C, 1, 32'h004, 32'hFFFF_FFFC);
    tbl[6]  = mk(0, 0, 32'h0,   1, 32'h010, 1, 32'h008, 32'h0000_0000);
    tbl[7]  = mk(0, 1, 32'h103, 0, 32'h014, 1, 32'h00C, 32'h0000_0004);
    tbl[8]  = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h000, 32'h0);
    tbl[9]  = mk(0, 0, 32'h0,   1, 32'h104, 0, 32'h000, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,   1, 32'h108, 1, 32'h100, 32'h100);
    tbl[11] = mk(1, 0, 32'h0,   0, 32'h10C, 1, 32'h104, 32'h104);
    tbl[12] = mk(1, 1, 32'h40,  0, 32'h10C, 1, 32'h104, 32'h104);
    tbl[13] = mk(0, 1, 32'h80,  0, 32'h040, 0, 32'h000, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,   1, 32'h080, 0, 32'h000, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,   1, 32'h084, 0, 32'h000, 32'h0);
    tbl[16] = mk(0, 0, 32'h0,   1, 32'h088, 1, 32'h080, 32'h080);

    rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    rom_data = 32'h0; rom_data_w = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce",    {31'd0, ce},    32'd0);
    check("rst_addr",  addr,           32'h0000_0000);
    check("rst_waddr", w_addr,         32'hFFFF_FFF8);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_inst",  inst,           32'h0);
    check("rst_pc",    pc,             32'h0);
    rst = 1'b0;

    // Directed table: startup, stall/release, branches, wrap instance.
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].s, tbl[i].b, tbl[i].t);
      check($sformatf("tbl%0d_ce", i),     {31'd0, s_ce},     {31'd0, tbl[i].e_ce});
      check($sformatf("tbl%0d_addr", i),   s_addr,            tbl[i].e_addr);
      check($sformatf("tbl%0d_valid", i),  {31'd0, s_valid},  {31'd0, tbl[i].e_valid});
      check($sformatf("tbl%0d_wvalid", i), {31'd0, s_wvalid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_pc", i),    s_pc,    tbl[i].e_pc);
        check($sformatf("tbl%0d_inst", i),  s_inst,  rom_fn(tbl[i].e_pc));
        check($sformatf("tbl%0d_wpc", i),   s_wpc,   tbl[i].e_wpc);
        check($sformatf("tbl%0d_winst", i), s_winst, rom_fn(tbl[i].e_wpc));
      end
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      bit          s, b;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else                           t = $urandom;
      cycle(s, b, t);
    end

    // Fill the FIFO, then assert reset between clock edges.
    repeat (3) cycle(0, 0, 32'h0);
    repeat (2) cycle(1, 0, 32'h0);
    check("pre_rst_occ2", {31'd0, valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", {31'd0, valid}, 32'd0);
    check("async_ce",    {31'd0, ce},    32'd0);
    check("async_addr",  addr,           32'h0000_0000);
    check("async_pc",    pc,             32'h0);
    stall = 1'b0; br = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 32'h0);
    check("restart_addr", s_addr, 32'h0000_0000);
    repeat (6) cycle(0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
